// File: rtl/wb_nor_arbiter_pkg.sv
// Shared constants and types for the NOR-controller Wishbone arbiter.
package wb_nor_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_e;

    // One-hot grant encodings as seen on grant_o
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Round-robin tie break: the master that did not own the bus last wins.
    function automatic arb_state_e tie_winner(input logic last_was_m1);
        arb_state_e st;
        if (last_was_m1) begin
            st = ST_GNT0;
        end else begin
            st = ST_GNT1;
        end
        return st;
    endfunction

endpackage

// File: rtl/wb_nor_arbiter_if.sv
// Pipelined Wishbone bus bundle; "master" drives a request, "slave" answers it.
interface wb_nor_arbiter_if #(
    parameter int DATABITS = 16
);
    logic                cyc;
    logic                stb;
    logic                we;
    logic [31:0]         adr;
    logic [DATABITS-1:0] dat_w;
    logic [DATABITS-1:0] dat_r;
    logic                ack;
    logic                err;
    logic                stall;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  dat_r, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output dat_r, ack, err, stall
    );
endinterface

// File: rtl/wb_nor_arbiter_txn_tracker.sv
// Outstanding-request counter, pipeline-full flag and hung-cycle timer.
module wb_nor_arbiter_txn_tracker #(
    parameter int MAX_OUTST      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic i_accept,   // request issued to the slave this cycle
    input  logic i_resp,     // raw slave ack or err this cycle
    input  logic i_active,   // a master currently owns the bus
    input  logic i_clear,    // drop all tracking state (dead cycle between tenures)
    output logic o_outst_nz,
    output logic o_pipe_full,
    output logic o_to_fire
);
    localparam int CW = $clog2(MAX_OUTST) + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(MAX_OUTST);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);
    localparam logic [TW-1:0] TMR_ZERO  = TW'(0);

    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_timer;
    logic          w_resp;
    logic          w_timer_run;

    // Late responses with nothing outstanding are ignored entirely.
    assign w_resp      = i_resp && (r_cnt != CNT_ZERO);
    assign o_outst_nz  = (r_cnt != CNT_ZERO);
    assign o_pipe_full = (r_cnt == CNT_FULL);
    assign w_timer_run = i_active && (r_cnt != CNT_ZERO) && !i_resp;
    assign o_to_fire   = (TIMEOUT_CYCLES != 0) && i_active &&
                         (r_cnt != CNT_ZERO) && (r_timer == TMR_LAST);

    // Count issued-but-unanswered requests and time how long the slave has been silent.
    always_ff @(posedge clk_i) begin
        if (reset_i || i_clear || o_to_fire) begin
            r_cnt   <= CNT_ZERO;
            r_timer <= TMR_ZERO;
        end else begin
            case ({i_accept, w_resp})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
            if (w_timer_run && (TIMEOUT_CYCLES != 0)) begin
                r_timer <= r_timer + TMR_ONE;
            end else begin
                r_timer <= TMR_ZERO;
            end
        end
    end
endmodule

// File: rtl/wb_nor_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the NOR cycle controller.
// Master 0 is the QSPI control FSM, master 1 the scrub/VT-scan sequencer.
module wb_nor_arbiter
    import wb_nor_arbiter_pkg::*;
#(
    parameter int DATABITS       = 16,
    parameter int MAX_OUTST      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk_i,
    input  logic              reset_i,
    wb_nor_arbiter_if.slave   m0,
    wb_nor_arbiter_if.slave   m1,
    wb_nor_arbiter_if.master  s,
    output logic [1:0]        grant_o,
    output logic              timeout_o
);
    arb_state_e r_state;
    logic [1:0] r_grant;
    logic       r_last_m1;

    logic w_accept;
    logic w_resp;
    logic w_active;
    logic w_clear;
    logic w_outst_nz;
    logic w_pipe_full;
    logic w_to_fire;

    assign w_accept  = s.stb && !s.stall;
    assign w_resp    = s.ack || s.err;
    assign w_active  = (r_state == ST_GNT0) || (r_state == ST_GNT1);
    assign w_clear   = (r_state == ST_GAP);
    assign grant_o   = r_grant;
    assign timeout_o = w_to_fire;

    wb_nor_arbiter_txn_tracker #(
        .MAX_OUTST      (MAX_OUTST),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tracker (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .i_accept    (w_accept),
        .i_resp      (w_resp),
        .i_active    (w_active),
        .i_clear     (w_clear),
        .o_outst_nz  (w_outst_nz),
        .o_pipe_full (w_pipe_full),
        .o_to_fire   (w_to_fire)
    );

    // Grant FSM: registered grant held for the owner's whole cyc tenure, one dead cycle after.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_grant   <= GNT_NONE;
            r_last_m1 <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m0.cyc && m1.cyc) begin
                        r_state <= tie_winner(r_last_m1);
                        r_grant <= r_last_m1 ? GNT_M0 : GNT_M1;
                    end else if (m0.cyc) begin
                        r_state <= ST_GNT0;
                        r_grant <= GNT_M0;
                    end else if (m1.cyc) begin
                        r_state <= ST_GNT1;
                        r_grant <= GNT_M1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_grant <= GNT_NONE;
                    end
                end
                ST_GNT0: begin
                    if (!m0.cyc) begin
                        r_state   <= ST_GAP;
                        r_grant   <= GNT_NONE;
                        r_last_m1 <= 1'b0;
                    end else begin
                        r_state <= ST_GNT0;
                    end
                end
                ST_GNT1: begin
                    if (!m1.cyc) begin
                        r_state   <= ST_GAP;
                        r_grant   <= GNT_NONE;
                        r_last_m1 <= 1'b1;
                    end else begin
                        r_state <= ST_GNT1;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                    r_grant <= GNT_NONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= GNT_NONE;
                end
            endcase
        end
    end

    // Bus steering: the owner sees the slave directly, the other master is held off.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = 32'h0000_0000;
        s.dat_w  = {DATABITS{1'b0}};
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.stall = 1'b1;
        m0.dat_r = {DATABITS{1'b0}};
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.stall = 1'b1;
        m1.dat_r = {DATABITS{1'b0}};
        case (r_state)
            ST_GNT0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb && !w_pipe_full;
                s.we     = m0.we;
                s.adr    = m0.adr;
                s.dat_w  = m0.dat_w;
                m0.stall = s.stall || w_pipe_full;
                m0.ack   = s.ack && w_outst_nz;
                m0.err   = (s.err && w_outst_nz) || w_to_fire;
                m0.dat_r = s.dat_r;
            end
            ST_GNT1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb && !w_pipe_full;
                s.we     = m1.we;
                s.adr    = m1.adr;
                s.dat_w  = m1.dat_w;
                m1.stall = s.stall || w_pipe_full;
                m1.ack   = s.ack && w_outst_nz;
                m1.err   = (s.err && w_outst_nz) || w_to_fire;
                m1.dat_r = s.dat_r;
            end
            default: begin
                s.cyc = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_wb_nor_arbiter.sv
// Directed, table-driven bench for wb_nor_arbiter.
module tb_wb_nor_arbiter;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    wb_nor_arbiter_if #(.DATABITS(16)) m0_bus ();
    wb_nor_arbiter_if #(.DATABITS(16)) m1_bus ();
    wb_nor_arbiter_if #(.DATABITS(16)) s_bus ();
    wb_nor_arbiter_if #(.DATABITS(16)) t_m0 ();
    wb_nor_arbiter_if #(.DATABITS(16)) t_m1 ();
    wb_nor_arbiter_if #(.DATABITS(16)) t_s ();

    logic [1:0] grant;
    logic       tmo;
    logic [1:0] t_grant;
    logic       t_tmo;

    wb_nor_arbiter #(.DATABITS(16), .MAX_OUTST(16), .TIMEOUT_CYCLES(4096)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .m0(m0_bus), .m1(m1_bus), .s(s_bus),
        .grant_o(grant), .timeout_o(tmo)
    );

    wb_nor_arbiter #(.DATABITS(16), .MAX_OUTST(16), .TIMEOUT_CYCLES(8)) u_dut_to (
        .clk_i(clk), .reset_i(reset_i), .m0(t_m0), .m1(t_m1), .s(t_s),
        .grant_o(t_grant), .timeout_o(t_tmo)
    );

    // inputs : rst m0c m0s m1c m1s ack err stl, slave read data
    // outputs: grant, scyc sstb m0stl m1stl m0ack m1ack m0err m1err, m0dat, m1dat
    typedef struct packed {
        logic rst, m0c, m0s, m1c, m1s, ack, err, stl;
        logic [15:0] sdat;
        logic [1:0]  gnt;
        logic scyc, sstb, m0stl, m1stl, m0ack, m1ack, m0err, m1err;
        logic [15:0] m0dat;
        logic [15:0] m1dat;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl [25];

    function automatic vec_t mk(input logic [7:0] in_b, input logic [15:0] sdat,
                                input logic [1:0] gnt, input logic [7:0] out_b,
                                input logic [15:0] m0dat, input logic [15:0] m1dat);
        vec_t x;
        {x.rst, x.m0c, x.m0s, x.m1c, x.m1s, x.ack, x.err, x.stl} = in_b;
        x.sdat = sdat;
        x.gnt  = gnt;
        {x.scyc, x.sstb, x.m0stl, x.m1stl, x.m0ack, x.m1ack, x.m0err, x.m1err} = out_b;
        x.m0dat = m0dat;
        x.m1dat = m1dat;
        return x;
    endfunction

    task automatic apply(input string name, input vec_t v);
        logic [41:0] got;
        logic [41:0] exp;
        @(negedge clk);
        reset_i      = v.rst;
        m0_bus.cyc   = v.m0c;
        m0_bus.stb   = v.m0s;
        m1_bus.cyc   = v.m1c;
        m1_bus.stb   = v.m1s;
        s_bus.ack    = v.ack;
        s_bus.err    = v.err;
        s_bus.stall  = v.stl;
        s_bus.dat_r  = v.sdat;
        #1;
        got = {grant, s_bus.cyc, s_bus.stb, m0_bus.stall, m1_bus.stall,
               m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err, m0_bus.dat_r, m1_bus.dat_r};
        exp = {v.gnt, v.scyc, v.sstb, v.m0stl, v.m1stl,
               v.m0ack, v.m1ack, v.m0err, v.m1err, v.m0dat, v.m1dat};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got gnt=%b flags=%b dat0=%h dat1=%h, want gnt=%b flags=%b dat0=%h dat1=%h",
                     name, got[41:40], got[39:32], got[31:16], got[15:0],
                     exp[41:40], exp[39:32], exp[31:16], exp[15:0]);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    initial begin
        int   n_acc;
        logic stall_ok;

        reset_i = 1'b1;
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0;
        m0_bus.adr = 32'h0400_0010; m0_bus.dat_w = 16'h0000;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
        m1_bus.adr = 32'h0800_0020; m1_bus.dat_w = 16'h0000;
        s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.stall = 1'b0; s_bus.dat_r = 16'h0000;
        t_m0.cyc = 1'b0; t_m0.stb = 1'b0; t_m0.we = 1'b0;
        t_m0.adr = 32'h0400_0010; t_m0.dat_w = 16'h0000;
        t_m1.cyc = 1'b0; t_m1.stb = 1'b0; t_m1.we = 1'b0;
        t_m1.adr = 32'h0000_0000; t_m1.dat_w = 16'h0000;
        t_s.ack = 1'b0; t_s.err = 1'b0; t_s.stall = 1'b0; t_s.dat_r = 16'h0000;

        // single m0 read, slave acks two cycles after the accept
        tbl[0]  = mk(8'b0000_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000);
        tbl[1]  = mk(8'b0110_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000);
        tbl[2]  = mk(8'b0110_0000, 16'h0000, 2'b01, 8'b1101_0000, 16'h0000, 16'h0000);
        tbl[3]  = mk(8'b0100_0000, 16'h0000, 2'b01, 8'b1001_0000, 16'h0000, 16'h0000);
        tbl[4]  = mk(8'b0100_0100, 16'hBEEF, 2'b01, 8'b1001_1000, 16'hBEEF, 16'h0000);
        tbl[5]  = mk(8'b0000_0000, 16'h0000, 2'b01, 8'b0001_0000, 16'h0000, 16'h0000);
        tbl[6]  = mk(8'b0000_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000);
        tbl[7]  = mk(8'b0000_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000);
        // reset, then simultaneous requests alternate 01,10,01
        tbl[8]  = mk(8'b1000_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000);
        tbl[9]  = mk(8'b0101_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000);
        tbl[10] = mk(8'b0101_0000, 16'h0000, 2'b01, 8'b1001_0000, 16'h0000, 16'h0000);
        tbl[11] = mk(8'b0001_0000, 16'h0000, 2'b01, 8'b0001_0000, 16'h0000, 16'h0000);
        tbl[12] = mk(8'b0001_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000);
        tbl[13] = mk(8'b0001_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000);
        tbl[14] = mk(8'b0001_0000, 16'h0000, 2'b10, 8'b1010_0000, 16'h0000, 16'h0000);
        tbl[15] = mk(8'b0101_0000, 16'h0000, 2'b10, 8'b1010_0000, 16'h0000, 16'h0000);
        tbl[16] = mk(8'b0100_0000, 16'h0000, 2'b10, 8'b0010_0000, 16'h0000, 16'h0000);
        tbl[17] = mk(8'b0101_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000);
        tbl[18] = mk(8'b0101_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000);
        tbl[19] = mk(8'b0101_0000, 16'h0000, 2'b01, 8'b1001_0000, 16'h0000, 16'h0000);
        // slave error forwarded, slave stall forwarded
        tbl[20] = mk(8'b0111_0000, 16'h0000, 2'b01, 8'b1101_0000, 16'h0000, 16'h0000);
        tbl[21] = mk(8'b0101_0010, 16'h0000, 2'b01, 8'b1001_0010, 16'h0000, 16'h0000);
        tbl[22] = mk(8'b0111_0001, 16'h0000, 2'b01, 8'b1111_0000, 16'h0000, 16'h0000);
        tbl[23] = mk(8'b0000_0000, 16'h0000, 2'b01, 8'b0001_0000, 16'h0000, 16'h0000);
        tbl[24] = mk(8'b0000_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("rst_adr", s_bus.adr, 32'h0000_0000);
        chk("rst_timeout", {31'd0, tmo}, 32'd0);

        for (int i = 0; i < 25; i++) begin
            apply($sformatf("tbl%0d", i), tbl[i]);
        end

        // pipeline-depth limit: m0 holds stb for 24 cycles, nothing is acked
        n_acc    = 0;
        stall_ok = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
            m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
            s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.stall = 1'b0; s_bus.dat_r = 16'h0000;
            #1;
            if (i == 1) begin
                chk("m0_adr", s_bus.adr, 32'h0400_0010);
            end
            if (n_acc == 16 && (m0_bus.stall !== 1'b1 || s_bus.stb !== 1'b0)) begin
                stall_ok = 1'b0;
            end
            if (s_bus.stb && !s_bus.stall) begin
                n_acc++;
            end
        end
        chk("pipe_accepts", n_acc, 32'd16);
        chk("pipe_stall_hold", {31'd0, stall_ok}, 32'd1);
        apply("full_ack",    mk(8'b0110_0100, 16'h0000, 2'b01, 8'b1011_1000, 16'h0000, 16'h0000));
        apply("full_reopen", mk(8'b0110_0000, 16'h0000, 2'b01, 8'b1101_0000, 16'h0000, 16'h0000));
        apply("full_again",  mk(8'b0110_0000, 16'h0000, 2'b01, 8'b1011_0000, 16'h0000, 16'h0000));
        apply("pipe_drop",   mk(8'b0000_0000, 16'h0000, 2'b01, 8'b0011_0000, 16'h0000, 16'h0000));
        apply("pipe_gap",    mk(8'b0000_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000));

        // abandoned tenure: late acks must not reach either master
        apply("ab_req",   mk(8'b0110_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000));
        apply("ab_s1",    mk(8'b0110_0000, 16'h0000, 2'b01, 8'b1101_0000, 16'h0000, 16'h0000));
        apply("ab_s2",    mk(8'b0110_0000, 16'h0000, 2'b01, 8'b1101_0000, 16'h0000, 16'h0000));
        apply("ab_s3",    mk(8'b0110_0000, 16'h0000, 2'b01, 8'b1101_0000, 16'h0000, 16'h0000));
        apply("ab_drop",  mk(8'b0001_0000, 16'h0000, 2'b01, 8'b0001_0000, 16'h0000, 16'h0000));
        apply("ab_late1", mk(8'b0001_0100, 16'h1111, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000));
        apply("ab_late2", mk(8'b0001_0100, 16'h2222, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000));
        apply("ab_late3", mk(8'b0001_1100, 16'h3333, 2'b10, 8'b1110_0000, 16'h0000, 16'h3333));
        apply("ab_m1ack", mk(8'b0001_0100, 16'h1234, 2'b10, 8'b1010_0100, 16'h0000, 16'h1234));
        chk("m1_adr", s_bus.adr, 32'h0800_0020);

        // reset in GNT1 with 5 outstanding, then a normal m0 read
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("rs_s%0d", i), mk(8'b0001_1000, 16'h0000, 2'b10, 8'b1110_0000, 16'h0000, 16'h0000));
        end
        apply("rs_reset",  mk(8'b1001_0000, 16'h0000, 2'b10, 8'b1010_0000, 16'h0000, 16'h0000));
        apply("rs_after",  mk(8'b0000_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000));
        apply("rs_m0_req", mk(8'b0110_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000));
        apply("rs_m0_g",   mk(8'b0110_0000, 16'h0000, 2'b01, 8'b1101_0000, 16'h0000, 16'h0000));
        apply("rs_m0_ack", mk(8'b0100_0100, 16'h5A5A, 2'b01, 8'b1001_1000, 16'h5A5A, 16'h0000));
        apply("rs_drop",   mk(8'b0000_0000, 16'h0000, 2'b01, 8'b0001_0000, 16'h0000, 16'h0000));
        apply("rs_gap",    mk(8'b0000_0000, 16'h0000, 2'b00, 8'b0011_0000, 16'h0000, 16'h0000));

        // timeout on the 8-cycle instance: one accepted read, slave silent
        @(negedge clk);
        t_m0.cyc = 1'b1; t_m0.stb = 1'b1;
        @(negedge clk);
        #1;
        chk("to_accept", {31'd0, (t_s.stb && !t_s.stall)}, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            t_m0.stb = 1'b0;
            #1;
            chk($sformatf("to_cycle%0d", k), {30'd0, t_m0.err, t_tmo},
                (k == 8) ? 32'd3 : 32'd0);
        end
        @(negedge clk);
        t_s.ack = 1'b1;
        #1;
        chk("to_cleared", {31'd0, t_m0.ack}, 32'd0);
        chk("to_grant_kept", {30'd0, t_grant}, 32'd1);
        @(negedge clk);
        t_s.ack = 1'b0;
        t_m0.cyc = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
